cpu_sequencer: RTL
==================

# cpu_sequencer

Multi-cycle control unit for the 16-bit, four-field instruction datapath (rs1[15:12], rs2[11:8], rd/imm[7:4], op[3:0]). It owns the 10-bit program counter, which drives the instruction decoder's read address. It steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the ALU, register-file and data-memory enables. It sits between the instruction decoder (upstream) and the register file, ALU and data memory (downstream).

## Interface
- RESET_PC, 10'd0, PC value loaded on reset.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  leaves IDLE; sampled only in IDLE.
- op  in  4  opcode from the decoder's registered op output.
- imm  in  4  the decoder's registered write_reg field, used as a signed branch offset.
- zero  in  1  ALU zero flag; sampled only in EXECUTE.
- mem_ack  in  1  data-memory completion; sampled only in MEMORY.
- pc  out  10  instruction address to the decoder.
- alu_op  out  4  ALU function; equals op_q in EXECUTE, else 0.
- reg_write  out  1  register-file write strobe.
- mem_read  out  1  load request, held until ack.
- mem_write  out  1  store request, held until ack.
- halted  out  1  high in HALT state.
- illegal  out  1  sticky; set on an undefined opcode.
- state  out  3  current state, for debug.

## Operation
- Opcode map:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT (ALU ops)
  - 7 LW, 8 SW
  - 9 BEQ, A JMP
  - F HALT
  - B–E undefined: executed as NOP and set `illegal`.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6.
- IDLE -> FETCH when start=1.
- FETCH -> DECODE unconditionally. PC is stable; the decoder captures ram[pc] on this edge.
- DECODE -> EXECUTE. Latch op_q<=op and imm_q<=imm on this edge. A HALT opcode goes DECODE -> HALT instead.
- EXECUTE transitions by opcode:
  - ALU ops -> WRITEBACK.
  - LW/SW -> MEMORY.
  - NOP, BEQ, JMP, undefined -> FETCH, with PC update on the same edge.
- MEMORY: stay while mem_ack=0.
  - On mem_ack=1, LW -> WRITEBACK.
  - On mem_ack=1, SW -> FETCH with PC update.
- WRITEBACK -> FETCH with PC update.
- HALT: absorbing; only rst leaves it. `start` is ignored.
- PC update:
  - Default is pc+1.
  - BEQ with zero=1, or JMP: pc+1+sext(imm_q).
  - All arithmetic is 10-bit modulo 1024, so 1023+1 wraps to 0 and 0+1+(-8) yields 1017.
- Output timing:
  - mem_read/mem_write are high for every MEMORY cycle of LW/SW respectively.
  - reg_write is high for exactly the one WRITEBACK cycle.
  - All outputs are Moore, decoded from the state register and op_q (no combinational path from inputs).

## Timing
- Reset values: pc=RESET_PC, state=IDLE, op_q=0, imm_q=0, alu_op=0, reg_write=0, mem_read=0, mem_write=0, halted=0, illegal=0.
- Reset is asynchronous. Asserting it mid-instruction (any state, including MEMORY with a request outstanding) immediately drops all strobes and returns to IDLE with pc=RESET_PC.
- Cycles per instruction (FETCH entry to next FETCH entry):
  - NOP/BEQ/JMP/undefined: 3.
  - ALU: 4.
  - SW: 3+N.
  - LW: 4+N.
  - N ≥ 1 is the number of MEMORY cycles. N=1 when mem_ack is already high on the first MEMORY cycle.
- mem_ack outside MEMORY is ignored. zero outside EXECUTE is ignored.
- PC changes only on the final edge of an instruction, never during FETCH/DECODE.
- `illegal` sets on the DECODE->EXECUTE edge and clears only on rst.
- start=1 held continuously has no effect after leaving IDLE.

## Test plan
- Reset then start pulse, ram = {0x1231 ADD, 0x0000 NOP} -> pc: 0 for 4 cycles, then 1. reg_write high exactly in cycle 4 with alu_op=1 in cycle 3.
- LW (0x1207) with mem_ack delayed 3 cycles -> mem_read high for 3 consecutive cycles, then one reg_write pulse, pc 0->1 after 7 cycles.
- BEQ at pc=5 with imm=4'hE (-2): zero=1 -> pc=4; zero=0 -> pc=6. JMP at pc=0 with imm=4'h8 -> pc=1017.
- PC at 1023 executing NOP -> pc wraps to 0. Opcode 0xC -> behaves as NOP, illegal=1 and stays 1 across later instructions.
- HALT (0x000F) at pc=2 -> state=6, halted=1, pc stays 2; start pulses ignored. rst returns to IDLE with halted=0.
- rst asserted during MEMORY of SW with mem_write high -> mem_write=0 and pc=0 in the same cycle, state=IDLE. Execution resumes correctly after start.

Source files
------------

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control unit
//                owning the 10-bit PC for the four-field 16-bit datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter logic [9:0] RESET_PC = 10'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] op,
    input  logic [3:0] imm,
    input  logic       zero,
    input  logic       mem_ack,
    output logic [9:0] pc,
    output logic [3:0] alu_op,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       halted,
    output logic       illegal,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_SLT  = 4'h6;
    localparam logic [3:0] c_OP_LW   = 4'h7;
    localparam logic [3:0] c_OP_SW   = 4'h8;
    localparam logic [3:0] c_OP_BEQ  = 4'h9;
    localparam logic [3:0] c_OP_JMP  = 4'hA;
    localparam logic [3:0] c_OP_UDLO = 4'hB;
    localparam logic [3:0] c_OP_UDHI = 4'hE;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    state_t     r_state;
    state_t     w_next_state;
    logic [9:0] r_pc;
    logic [9:0] w_pc_next;
    logic [3:0] r_op_q;
    logic [3:0] r_imm_q;
    logic       r_illegal;
    logic       w_latch_op;
    logic       w_set_illegal;

    logic       w_is_alu;
    logic       w_is_mem;
    logic       w_take_branch;
    logic [9:0] w_pc_inc;
    logic [9:0] w_pc_target;

    assign w_is_alu      = (r_op_q >= c_OP_ADD) && (r_op_q <= c_OP_SLT);
    assign w_is_mem      = (r_op_q == c_OP_LW) || (r_op_q == c_OP_SW);
    assign w_take_branch = (r_op_q == c_OP_JMP) || ((r_op_q == c_OP_BEQ) && zero);
    assign w_pc_inc      = r_pc + 10'd1;
    // imm_q is a signed 4-bit offset relative to the following instruction.
    assign w_pc_target   = w_pc_inc + {{6{r_imm_q[3]}}, r_imm_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_op_q    <= 4'd0;
            r_imm_q   <= 4'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            if (w_latch_op) begin
                r_op_q  <= op;
                r_imm_q <= imm;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_pc_next     = r_pc;
        w_latch_op    = 1'b0;
        w_set_illegal = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                w_latch_op = 1'b1;
                if (op == c_OP_HALT) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state  = S_EXECUTE;
                    w_set_illegal = (op >= c_OP_UDLO) && (op <= c_OP_UDHI);
                end
            end
            S_EXECUTE: begin
                if (w_is_alu) begin
                    w_next_state = S_WRITEBACK;
                end else if (w_is_mem) begin
                    w_next_state = S_MEMORY;
                end else begin
                    // NOP, BEQ, JMP and undefined opcodes retire here.
                    w_next_state = S_FETCH;
                    w_pc_next    = w_take_branch ? w_pc_target : w_pc_inc;
                end
            end
            S_MEMORY: begin
                if (mem_ack) begin
                    if (r_op_q == c_OP_LW) begin
                        w_next_state = S_WRITEBACK;
                    end else begin
                        w_next_state = S_FETCH;
                        w_pc_next    = w_pc_inc;
                    end
                end
            end
            S_WRITEBACK: begin
                w_next_state = S_FETCH;
                w_pc_next    = w_pc_inc;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Moore outputs: decoded only from the state register and op_q.
    assign pc        = r_pc;
    assign alu_op    = (r_state == S_EXECUTE) ? r_op_q : 4'd0;
    assign reg_write = (r_state == S_WRITEBACK);
    assign mem_read  = (r_state == S_MEMORY) && (r_op_q == c_OP_LW);
    assign mem_write = (r_state == S_MEMORY) && (r_op_q == c_OP_SW);
    assign halted    = (r_state == S_HALT);
    assign illegal   = r_illegal;
    assign state     = r_state;

endmodule
`default_nettype wire
